hdmi_stream_aligner: RTL and testbench
======================================

HDMI_STREAM_ALIGNER -- requirements
Module: hdmi_stream_aligner

Interface
REQ-001 Parameter WIDTH, default 1280, active pixels per line.
REQ-002 Parameter HEIGHT, default 720, active lines per frame.
REQ-003 Parameter FILL_COLOR, default 16'h2277, RGB565 value driven when no pixel is available.
REQ-004 Port clk  input  1  pixel clock; the block SHALL use one clock, and all logic is on its rising edge.
REQ-005 Port rst_n  input  1  reset; the block SHALL use a synchronous, active-low reset.
REQ-006 Port pixel_tvalid  input  1  AXIS valid from the upstream pixel stream.
REQ-007 Port pixel_tdata  input  16  RGB565 pixel.
REQ-008 Port pixel_tlast  input  1  marks the last pixel of a frame.
REQ-009 Port pixel_tready  output  1  AXIS ready, combinational.
REQ-010 Port active_draw  input  1  HDMI active-video flag.
REQ-011 Port h_count  input  11  HDMI horizontal position.
REQ-012 Port v_count  input  10  HDMI vertical position.
REQ-013 Port pixel_out  output  16  registered display pixel.
REQ-014 Port pixel_out_valid  output  1  registered copy of active_draw.
REQ-015 Port aligned  output  1  high while state is STREAM.
REQ-016 Port underflow_count  output  16  saturating count of starved active pixels.
REQ-017 Port resync_count  output  8  saturating count of frame misalignments.

Function
REQ-018 The FSM SHALL have three states: HUNT, ARMED, STREAM.
REQ-019 HUNT: pixel_tready=1, so all beats are discarded; an accepted beat with tlast=1 SHALL move the FSM to ARMED.
- pixel_tready=0 by default.
- At active_draw && h_count==0 && v_count==0, pixel_tready=1 and the FSM SHALL move to STREAM.
REQ-020 ARMED: if a beat is accepted in that cycle, it is the frame's first pixel.
REQ-021 STREAM: pixel_tready SHALL equal active_draw.
REQ-022 Define "last position" as h_count==WIDTH-1 && v_count==HEIGHT-1. On an accepted beat in STREAM or on the ARMED exit, tlast=1 at a non-last position SHALL be an early tlast.
- Early tlast: FSM goes to ARMED, resync_count increments.
REQ-023 On an accepted beat at last position with tlast=0 (late tlast), the FSM SHALL go to HUNT and resync_count SHALL increment.
REQ-024 On an accepted beat at last position with tlast=1, the FSM SHALL stay in STREAM with no count change.
REQ-025 In STREAM with active_draw=1 and pixel_tvalid=0, underflow_count SHALL increment by one per cycle.
- The screen position still advances, so there is no state change.
REQ-026 pixel_out SHALL have latency 1: it becomes pixel_tdata if a beat was accepted in the previous cycle while in ARMED or STREAM, else FILL_COLOR.
REQ-027 pixel_out_valid SHALL be active_draw delayed by one cycle.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.
REQ-029 Beats discarded in HUNT SHALL never reach pixel_out.
REQ-030 Inactive video in STREAM: pixel_tready=0 and no counting SHALL occur.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL set:
- state = HUNT
- pixel_out = FILL_COLOR
- pixel_out_valid = 0
- aligned = 0
- both counters = 0
REQ-032 Reset mid-frame SHALL drop the in-progress alignment, so that the first STREAM entry after reset requires a new tlast plus a (0,0) frame start.
REQ-033 pixel_tready SHALL be 1 during reset because state is HUNT; the beats accepted then are discarded.

Configuration
REQ-034 With the macro HDMI_STREAM_ALIGNER_STATS_EN defined, underflow_count and resync_count SHALL behave per REQ-025, REQ-022, REQ-023 and REQ-028.
REQ-035 Without HDMI_STREAM_ALIGNER_STATS_EN, both counter outputs SHALL be constant 0 and no counter registers SHALL be synthesized.
- FSM and datapath behaviour SHALL be identical.

Verification
REQ-036 After reset, feed beats with tlast on beat 5, then a frame whose first pixel is 16'h1234 -> discarded beats never appear on pixel_out; aligned rises after the (0,0) cycle; pixel_out=16'h1234 one cycle after (0,0).
REQ-037 Steady stream, two full 1280x720 frames with tlast at (1279,719) -> aligned=1 throughout; resync_count=0; underflow_count=0.
REQ-038 Deassert pixel_tvalid for 3 active cycles mid-line -> pixel_out=16'h2277 for those 3 cycles; underflow_count=3; aligned stays 1.
REQ-039 tlast at (100,719) -> state ARMED; resync_count=1; pixel_out=FILL_COLOR until the next (0,0).
- tlast missing at (1279,719) -> state HUNT; resync_count increments.
REQ-040 Assert rst_n=0 for 1 cycle mid-frame while in STREAM -> next cycle aligned=0, pixel_out=16'h2277, both counters=0.
REQ-041 Build without STATS_EN and repeat REQ-038 -> pixel_out is identical and underflow_count=0.

Source files
------------

// File: rtl/hdmi_stream_aligner.sv
// Aligns an AXIS RGB565 frame stream to HDMI raster timing (HUNT -> ARMED -> STREAM).
// Define HDMI_STREAM_ALIGNER_STATS_EN to build the underflow/resync counters; otherwise they read 0.
module hdmi_stream_aligner #(
   parameter int          WIDTH      = 1280,
   parameter int          HEIGHT     = 720,
   parameter logic [15:0] FILL_COLOR = 16'h2277
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pixel_tvalid,
   input  logic [15:0] pixel_tdata,
   input  logic        pixel_tlast,
   output logic        pixel_tready,
   input  logic        active_draw,
   input  logic [10:0] h_count,
   input  logic [9:0]  v_count,
   output logic [15:0] pixel_out,
   output logic        pixel_out_valid,
   output logic        aligned,
   output logic [15:0] underflow_count,
   output logic [7:0]  resync_count
);

   typedef enum logic [1:0] {HUNT, ARMED, STREAM} state_t;

   state_t      state_q, state_d;
   logic [15:0] pixel_out_q, pixel_out_d;
   logic        pixel_out_valid_q, pixel_out_valid_d;
   logic        accept, frame_start, last_pos, resync, underflow;

   always_comb begin
      frame_start = active_draw && (h_count == 11'd0) && (v_count == 10'd0);
      last_pos    = (h_count == 11'(WIDTH - 1)) && (v_count == 10'(HEIGHT - 1));
      state_d     = state_q;
      resync      = 1'b0;
      underflow   = 1'b0;
      case (state_q)
         HUNT:    pixel_tready = 1'b1;
         ARMED:   pixel_tready = frame_start;
         STREAM:  pixel_tready = active_draw;
         default: pixel_tready = 1'b1;
      endcase
      // Reset forces HUNT, so the stream is drained (and discarded) while held.
      if (!rst_n) pixel_tready = 1'b1;
      accept = pixel_tvalid && pixel_tready;

      case (state_q)
         HUNT: if (accept && pixel_tlast) state_d = ARMED;
         ARMED, STREAM: begin
            if (state_q == STREAM || frame_start) begin
               state_d = STREAM;
               if (accept) begin
                  if (pixel_tlast && !last_pos) begin
                     state_d = ARMED;
                     resync  = 1'b1;
                  end else if (!pixel_tlast && last_pos) begin
                     state_d = HUNT;
                     resync  = 1'b1;
                  end
               end else if (state_q == STREAM && active_draw) begin
                  underflow = 1'b1;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      pixel_out_d       = (accept && state_q != HUNT) ? pixel_tdata : FILL_COLOR;
      pixel_out_valid_d = active_draw;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= HUNT;
         pixel_out_q       <= FILL_COLOR;
         pixel_out_valid_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         pixel_out_q       <= pixel_out_d;
         pixel_out_valid_q <= pixel_out_valid_d;
      end
   end

   assign pixel_out       = pixel_out_q;
   assign pixel_out_valid = pixel_out_valid_q;
   assign aligned         = (state_q == STREAM);

`ifdef HDMI_STREAM_ALIGNER_STATS_EN
   logic [15:0] underflow_count_q, underflow_count_d;
   logic [7:0]  resync_count_q, resync_count_d;

   // Both counters stick at all-ones instead of wrapping.
   always_comb begin
      underflow_count_d = underflow_count_q;
      resync_count_d    = resync_count_q;
      if (underflow && underflow_count_q != 16'hFFFF) underflow_count_d = underflow_count_q + 16'd1;
      if (resync && resync_count_q != 8'hFF)          resync_count_d    = resync_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         underflow_count_q <= 16'd0;
         resync_count_q    <= 8'd0;
      end else begin
         underflow_count_q <= underflow_count_d;
         resync_count_q    <= resync_count_d;
      end
   end

   assign underflow_count = underflow_count_q;
   assign resync_count    = resync_count_q;
`else
   logic unused_stats;
   assign unused_stats    = resync ^ underflow;
   assign underflow_count = 16'd0;
   assign resync_count    = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_stream_aligner.sv
// Directed bench for hdmi_stream_aligner on a small 8x4 raster (10x6 total) with a per-cycle model.
module tb_hdmi_stream_aligner;
  localparam int W = 8, H = 4, HT = 10, VT = 6;
  localparam logic [15:0] FILL = 16'h2277;
`ifdef HDMI_STREAM_ALIGNER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, pixel_tvalid, pixel_tlast, pixel_tready, active_draw;
  logic [15:0] pixel_tdata, pixel_out, underflow_count;
  logic [10:0] h_count;
  logic [9:0] v_count;
  logic pixel_out_valid, aligned;
  logic [7:0] resync_count;

  always #5 clk = ~clk;

  hdmi_stream_aligner #(.WIDTH(W), .HEIGHT(H), .FILL_COLOR(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_tvalid(pixel_tvalid), .pixel_tdata(pixel_tdata),
    .pixel_tlast(pixel_tlast), .pixel_tready(pixel_tready), .active_draw(active_draw),
    .h_count(h_count), .v_count(v_count), .pixel_out(pixel_out),
    .pixel_out_valid(pixel_out_valid), .aligned(aligned),
    .underflow_count(underflow_count), .resync_count(resync_count));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Raster and source state
  int th, tv;
  logic src_on, src_gap;
  int src_cnt, src_len, src_len_nxt;
  logic [15:0] src_base, src_base_nxt;
  bit acc_smp = 1'b0;

  // Model: mode 0 = hunting, 1 = waiting for frame start, 2 = locked
  int m_mode = 0, m_uf = 0, m_rs = 0, seen_discard = 0;
  logic [15:0] m_pix = FILL;
  logic m_pv = 1'b0;

  always @(negedge clk) begin
    bit rdy, take, fs, lp;
    int prev;
    acc_smp = pixel_tvalid && pixel_tready;
    fs = active_draw && h_count == 0 && v_count == 0;
    lp = h_count == W - 1 && v_count == H - 1;
    rdy = !rst_n || m_mode == 0 || (m_mode == 1 && fs) || (m_mode == 2 && active_draw);
    chk("tready", pixel_tready, rdy);
    chk("pixel_out", pixel_out, m_pix);
    chk("pixel_out_valid", pixel_out_valid, m_pv);
    chk("aligned", aligned, m_mode == 2);
    chk("underflow_count", underflow_count, STATS ? m_uf : 0);
    chk("resync_count", resync_count, STATS ? m_rs : 0);
    if (pixel_out[15:8] == 8'hAA) seen_discard++;
    take = pixel_tvalid && rdy;
    prev = m_mode;
    if (!rst_n) begin
      m_mode = 0; m_pix = FILL; m_pv = 1'b0; m_uf = 0; m_rs = 0;
    end else begin
      m_pix = (take && prev != 0) ? pixel_tdata : FILL;
      m_pv = active_draw;
      if (prev == 0) begin
        if (take && pixel_tlast) m_mode = 1;
      end else if (prev == 2 || fs) begin
        m_mode = 2;
        if (take && pixel_tlast && !lp) begin m_mode = 1; if (m_rs < 255) m_rs++; end
        else if (take && !pixel_tlast && lp) begin m_mode = 0; if (m_rs < 255) m_rs++; end
        else if (!take && prev == 2 && active_draw && m_uf < 65535) m_uf++;
      end
    end
  end

  task automatic drive();
    h_count = 11'(th);
    v_count = 10'(tv);
    active_draw = (th < W) && (tv < H);
    pixel_tvalid = src_on && !src_gap;
    pixel_tdata = src_base + 16'(src_cnt);
    pixel_tlast = (src_cnt == src_len - 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (acc_smp) begin
      if (pixel_tlast) begin
        src_cnt = 0; src_len = src_len_nxt; src_base = src_base_nxt;
      end else src_cnt++;
    end
    #1;
    th++;
    if (th == HT) begin th = 0; tv++; if (tv == VT) tv = 0; end
    drive();
  endtask

  task automatic tick_until(input int h, input int v);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (th == h && tv == v) return;
    end
    n_chk++;
    $display("FAIL wait_pos: (%0d,%0d) not reached, got (%0d,%0d)", h, v, th, tv);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; th = 3; tv = 2;
    src_on = 1'b1; src_gap = 1'b0; src_cnt = 0; src_len = 5; src_len_nxt = W * H;
    src_base = 16'hAA00; src_base_nxt = 16'h1234;
    drive();
    repeat (3) tick();
    chk("rst pixel_out", pixel_out, 16'h2277);
    chk("rst valid", pixel_out_valid, 0);
    chk("rst aligned", aligned, 0);
    chk("rst tready", pixel_tready, 1);
    chk("rst counters", {underflow_count, resync_count}, 0);
    rst_n = 1'b1;

    // Lock onto first full frame
    tick_until(0, 0);
    chk("armed before 0,0", aligned, 0);
    tick();
    chk("first pixel", pixel_out, 16'h1234);
    chk("aligned after 0,0", aligned, 1);

    // Two steady frames
    bad = 0;
    repeat (2 * HT * VT) begin tick(); if (aligned !== 1'b1) bad++; end
    chk("aligned 2 frames", bad, 0);
    chk("steady resync", resync_count, 0);
    chk("steady underflow", underflow_count, 0);

    // Three-cycle starvation mid-line
    tick_until(3, 1);
    src_gap = 1'b1; drive();
    tick(); chk("gap fill 0", pixel_out, FILL);
    tick(); chk("gap fill 1", pixel_out, FILL);
    src_gap = 1'b0;
    tick(); chk("gap fill 2", pixel_out, FILL);
    chk("gap aligned", aligned, 1);
    chk("gap underflow", underflow_count, STATS ? 3 : 0);
    tick(); chk("resume pixel", pixel_out, 16'h123F);

    // Starvation leaves the source 3 beats behind: late tlast at last position
    tick_until(W - 1, H - 1);
    tick();
    chk("late tlast hunt", aligned, 0);
    chk("late tlast resync", resync_count, STATS ? 1 : 0);
    tick_until(0, 0);
    tick();
    chk("relock pixel", pixel_out, 16'h1234);
    chk("relock aligned", aligned, 1);

    // Early tlast at (2,3)
    src_len = W * 3 + 3;
    tick_until(2, H - 1);
    tick();
    chk("early tlast armed", aligned, 0);
    chk("early tlast resync", resync_count, STATS ? 2 : 0);
    chk("early tlast beat", pixel_out, 16'h124E);
    tick();
    chk("armed fill", pixel_out, FILL);
    tick_until(0, 0);
    tick();
    chk("early relock pixel", pixel_out, 16'h1234);

    // Single-cycle reset mid-frame
    tick_until(4, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst aligned", aligned, 0);
    chk("midrst pixel_out", pixel_out, 16'h2277);
    chk("midrst counters", {underflow_count, resync_count}, 0);
    tick_until(0, 0);
    tick();
    chk("post-rst relock", aligned, 1);
    chk("post-rst pixel", pixel_out, 16'h1234);
    repeat (HT * VT) tick();
    chk("no discarded beats shown", seen_discard, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
